// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, funct/ALUOp encodings and engine state type
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MUL   = 6'b011100;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - iterative shift-add multiplier / restoring divider with sign fixup
module iter_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_div,
  input  logic                  op_signed,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DW    = DATA_WIDTH;

  state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] qr_q, qr_d;
  logic [DW-1:0] b_q, b_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          dbz_q, dbz_d;

  logic          a_neg, b_neg;
  logic [DW-1:0] mag_a, mag_b;

  // acc holds the running high word (multiply) or partial remainder (divide);
  // qr holds the multiplier being consumed or the quotient being built.
  logic [DW:0]     mul_sum;
  logic [DW-1:0]   mul_acc, mul_qr;
  logic [DW:0]     div_sh, div_diff;
  logic [DW-1:0]   div_acc, div_qr;
  logic [DW-1:0]   iter_acc, iter_qr;
  logic [2*DW-1:0] prod, prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix;

  assign mul_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, b_q} : {(DW+1){1'b0}});
  assign mul_acc = mul_sum[DW:1];
  assign mul_qr  = {mul_sum[0], qr_q[DW-1:1]};

  assign div_sh   = {acc_q, qr_q[DW-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_acc  = div_diff[DW] ? div_sh[DW-1:0] : div_diff[DW-1:0];
  assign div_qr   = {qr_q[DW-2:0], ~div_diff[DW]};

  assign iter_acc = is_div_q ? div_acc : mul_acc;
  assign iter_qr  = is_div_q ? div_qr  : mul_qr;

  assign prod     = {iter_acc, iter_qr};
  assign prod_fix = neg_q  ? -prod     : prod;
  assign quo_fix  = neg_q  ? -iter_qr  : iter_qr;
  assign rem_fix  = rneg_q ? -iter_acc : iter_acc;

  assign a_neg = op_signed & src_a[DW-1];
  assign b_neg = op_signed & src_b[DW-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -src_b : src_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op_div;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          acc_d    = '0;
          qr_d     = mag_a;
          b_d      = mag_b;
          cnt_d    = '0;
          if (op_div && (src_b == '0)) begin
            state_d = ST_DONE;
            hi_d    = src_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = iter_acc;
        qr_d  = iter_qr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DW - 1)) begin
          state_d = ST_DONE;
          dbz_d   = 1'b0;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*DW-1:DW];
            lo_d = prod_fix[DW-1:0];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/alu_seq_decoder.sv
// rtl/alu_seq_decoder.sv - ALU control decode with long-op detection and Start qualification
module alu_seq_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3,
  parameter int ENABLE_DIV = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            ALUOp,
  input  logic [5:0]            Funct,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic [CTRL_WIDTH-1:0] ALU_Control,
  output logic                  MultiCycle,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output logic                  DivByZero
);

  logic [2:0] ctrl_code;
  logic       multi_cycle;
  logic       start_ok;
  logic       eng_busy;

  always_comb begin
    ctrl_code   = ALU_ADD;
    multi_cycle = 1'b0;
    case (ALUOp)
      ALUOP_ADD:  ctrl_code = ALU_ADD;
      ALUOP_SUB:  ctrl_code = ALU_SUB;
      ALUOP_ADD2: ctrl_code = ALU_ADD;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:            ctrl_code = ALU_ADD;
          FN_SUB:            ctrl_code = ALU_SUB;
          FN_SLT:            ctrl_code = ALU_SLT;
          FN_MUL:            ctrl_code = ALU_MUL;
          FN_AND:            ctrl_code = ALU_AND;
          FN_OR:             ctrl_code = ALU_OR;
          FN_MULT, FN_MULTU: multi_cycle = 1'b1;
          FN_DIV, FN_DIVU:   multi_cycle = (ENABLE_DIV != 0);
          default:           ctrl_code = ALU_ADD;
        endcase
      end
      default:    ctrl_code = ALU_ADD;
    endcase
  end

  // The engine is idle exactly when it is not busy, so this is the IDLE gate.
  assign start_ok = Start & multi_cycle & ~eng_busy;

  iter_muldiv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter_muldiv (
    .clk         (CLK),
    .rst         (RST),
    .start       (start_ok),
    .op_div      (Funct[1]),
    .op_signed   (~Funct[0]),
    .src_a       (SrcA),
    .src_b       (SrcB),
    .busy        (eng_busy),
    .done        (Done),
    .hi          (Hi),
    .lo          (Lo),
    .div_by_zero (DivByZero)
  );

  assign ALU_Control = CTRL_WIDTH'(ctrl_code);
  assign MultiCycle  = multi_cycle;
  assign Busy        = eng_busy;

endmodule
